// File: rtl/gate_model_bist.sv
//==============================================================================
// Module      : gate_model_bist
// Description : Self-test driver for combinational gate-library models.
//               An LFSR drives the model inputs, a MISR compacts the model
//               outputs, and a small sequencer runs PATTERNS vectors and then
//               compares the final signature against a golden value.
// Ports       : clk         - rising-edge clock
//               rst_n       - asynchronous active-low reset
//               start       - run request (sampled in IDLE / DONE only)
//               golden_sig  - expected signature (sampled in CHECK)
//               dut_in      - registered stimulus vector to the gate model
//               dut_out     - gate model response (combinational from dut_in)
//               busy        - high while a run is in progress (RUN, CHECK)
//               done        - high once a run has finished, until next start
//               pass        - signature matched golden_sig (valid with done)
//               signature   - final MISR value (valid with done)
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module gate_model_bist #(
    parameter int unsigned       IN_W     = 13,
    parameter int unsigned       OUT_W    = 10,
    parameter int unsigned       PATTERNS = 256,
    parameter logic [IN_W-1:0]   SEED     = 13'h0001
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [OUT_W-1:0] golden_sig,
    output logic [IN_W-1:0]  dut_in,
    input  logic [OUT_W-1:0] dut_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [OUT_W-1:0] signature
);

    // Wide enough to hold PATTERNS itself, so the counter never wraps in a run.
    localparam int unsigned       c_CNT_W = $clog2(PATTERNS + 1);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(PATTERNS - 1);
    // An all-zero seed would lock the LFSR, so it is forced to 1.
    localparam logic [IN_W-1:0]   c_SEED = (SEED == '0) ? IN_W'(1) : SEED;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_CHECK = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state_q;
    logic [IN_W-1:0]    dut_in_q;
    logic [OUT_W-1:0]   misr_q;
    logic [c_CNT_W-1:0] cnt_q;
    logic               busy_q;
    logic               done_q;
    logic               pass_q;
    logic [OUT_W-1:0]   sig_q;

    logic [IN_W-1:0]    lfsr_d;
    logic [OUT_W-1:0]   misr_d;

    // Fibonacci LFSR, x^13 + x^4 + x^3 + x + 1, stepping in place on dut_in.
    always_comb begin
        lfsr_d = {dut_in_q[IN_W-2:0],
                  dut_in_q[IN_W-1] ^ dut_in_q[3] ^ dut_in_q[2] ^ dut_in_q[0]};
    end

    // MISR, x^10 + x^3 + 1: shift left, fold the top bit back into bits 0
    // and 3, and xor in the model response.
    always_comb begin
        misr_d    = {misr_q[OUT_W-2:0], 1'b0} ^ dut_out;
        misr_d[0] = misr_d[0] ^ misr_q[OUT_W-1];
        misr_d[3] = misr_d[3] ^ misr_q[OUT_W-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            dut_in_q <= '0;
            misr_q   <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            sig_q    <= '0;
        end else begin
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        dut_in_q <= c_SEED;
                        misr_q   <= '0;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        done_q   <= 1'b0;
                        pass_q   <= 1'b0;
                        state_q  <= S_RUN;
                    end
                end
                S_RUN: begin
                    // Absorb the response to the vector currently applied,
                    // then advance to the next vector.
                    misr_q   <= misr_d;
                    dut_in_q <= lfsr_d;
                    cnt_q    <= cnt_q + c_CNT_W'(1);
                    if (cnt_q == c_LAST) begin
                        state_q <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    sig_q   <= misr_q;
                    pass_q  <= (misr_q == golden_sig);
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_DONE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign dut_in    = dut_in_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign signature = sig_q;

endmodule

`default_nettype wire

// File: doc/gate_model_bist.md
Name: gate_model_bist

Overview:
- Self-test driver for the combinational gate-library models (13 inputs, 10 outputs per model). It is the stimulus/response end of the model interface.
- An LFSR generates the input vectors that drive the model's inputs. A MISR compacts the model's outputs into a signature.
- A small FSM sequences one run of PATTERNS vectors and compares the final signature against a golden value.
- It sits between the simulator's test controller and any gate model instance, so a model can be checked without a full vector file.

Parameters:
- IN_W, 13, width of the vector driven into the gate model.
- OUT_W, 10, width of the response read back from the gate model.
- PATTERNS, 256, vectors applied per run; legal range 1..4095.
- SEED, 13'h0001, LFSR start value. A value of 0 is replaced by 1 at elaboration.

Ports:
- clk, input, 1, single clock; all state updates on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, request a run; sampled only in IDLE or DONE.
- golden_sig, input, OUT_W, expected signature; sampled in CHECK.
- dut_in, output, IN_W, registered vector to the gate model inputs.
- dut_out, input, OUT_W, gate model outputs (combinational from dut_in).
- busy, output, 1, high in RUN and CHECK.
- done, output, 1, high in DONE; held until the next start or reset.
- pass, output, 1, signature == golden_sig; valid while done.
- signature, output, OUT_W, final MISR value; valid while done.

Behaviour:
- Reset (rst_n low, asynchronous), all outputs and state cleared:
  - state=IDLE, dut_in=0, misr=0, cnt=0.
  - busy=0, done=0, pass=0, signature=0.
- LFSR (Fibonacci, x^13+x^4+x^3+x+1), in place on dut_in:
  - fb = q[12]^q[3]^q[2]^q[0].
  - next = {q[11:0], fb}.
- MISR (x^10+x^3+1):
  - m'[0] = m[9]^d[0].
  - m'[3] = m[2]^d[3]^m[9].
  - m'[i] = m[i-1]^d[i] for all other i.
  - d = dut_out.
- Counter: cnt is ceil(log2(PATTERNS+1)) bits wide and cannot wrap within a legal run.
- IDLE / DONE, start=1:
  - dut_in<=SEED, misr<=0, cnt<=0, done<=0, pass<=0; go to RUN.
  - start=0: hold state and all outputs.
- RUN, every edge:
  - misr<=MISR(misr, dut_out). This absorbs the response to the vector currently on dut_in.
  - dut_in<=LFSR(dut_in); cnt<=cnt+1.
  - If cnt==PATTERNS-1, go to CHECK.
  - start is ignored.
- CHECK, one cycle:
  - signature<=misr; pass<=(misr==golden_sig); done<=1; go to DONE.
  - dut_in holds its last value.
- Latency:
  - The edge that samples start is edge 0. Exactly PATTERNS responses are absorbed, on edges 1..PATTERNS.
  - done rises on edge PATTERNS+1.
  - busy is high from edge 0 through edge PATTERNS+1 (exclusive), i.e. for PATTERNS+1 cycles.
- Back-to-back runs: start while in DONE begins a fresh run on the same edge. done/pass drop and busy rises on that edge.
- Reset mid-run: immediate return to the reset state; no partial signature is reported.
- dut_out is sampled synchronously only. The gate model must settle within one clock period; this block adds no input registering.

Test Plan:
- LFSR sequence: PATTERNS=4, SEED=1, dut_out tied 0 -> dut_in takes 0x0001, 0x0003, 0x0007, 0x000E on consecutive RUN cycles; signature=0x000; pass=1 with golden_sig=0.
- MISR fold: PATTERNS=2, dut_out held 10'h001 -> signature=0x003. With golden_sig=0x003, pass=1; with golden_sig=0x002, pass=0.
- Latency/handshake: PATTERNS=8 -> busy high exactly 9 cycles; done rises on edge 9 after the start edge and stays high. A start pulse mid-run has no effect on cnt or dut_in.
- Back-to-back: start held high through DONE -> a second run begins immediately, done low for 9 cycles, identical signature reported.
- Reset mid-run: rst_n pulled low asynchronously at cnt=3 -> all outputs 0 without waiting for a clock edge, state IDLE; the next start reproduces the same signature as a clean run.
- Real model: connect a 13-in/10-out gate model, PATTERNS=256, golden_sig from the reference simulator -> pass=1. Flip one model output bit in the bench -> pass=0.
